ray_traversal_ctrl: RTL and testbench
=====================================

# ray_traversal_ctrl

Per-ray step sequencer that sits directly upstream of `voxel_raytracer_core`. It accepts one initialised ray and issues single steps into the core. It consumes each step result after the core's fixed latency and loops the returned position and timers back in. It stops on hit, grid exit, step limit or lost result, and presents a registered traversal result to the shading/output stage.

## Interface
Parameters:
- `W`, 32, timer width (matches core)
- `CORE_LAT`, 5, cycles from core `step_valid_in` to `step_valid_out`
- `MAX_STEPS`, 96, step limit before TIMEOUT
- `STEP_W`, 7, width of step counter/result

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `load_mode`  in  1  scene load active; blocks ray acceptance
- `ray_valid` / `ray_ready`  in/out  1  ray handshake
- `ray_ix`, `ray_iy`, `ray_iz`  in  5  start voxel
- `ray_sx`, `ray_sy`, `ray_sz`  in  1  step direction, 1 = +
- `ray_next_x/y/z`, `ray_inc_x/y/z`  in  W  initial timers and increments
- `step_ix/iy/iz`  out  5  to core
- `step_sx/sy/sz`  out  1  to core
- `step_next_x/y/z`, `step_inc_x/y/z`  out  W  to core
- `step_valid`  out  1  to core `step_valid_in`
- `core_ix/iy/iz`, `core_next_x/y/z`, `core_face_mask`[2:0], `core_face_id`[2:0], `core_oob`, `core_occupied`, `core_valid`  in  from core outputs
- `res_valid` / `res_ready`  out/in  1  result handshake
- `res_status`  out  2  0 HIT, 1 MISS, 2 TIMEOUT, 3 LOST
- `res_ix/iy/iz`  out  5  result voxel
- `res_face_id`  out  3  entry face of result voxel
- `res_steps`  out  STEP_W  steps completed
- `busy`  out  1  state != IDLE

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - `ray_ready = (state==IDLE) & !load_mode & rst_n`.
  - On accept: latch all ray fields into cur/dir/inc registers; clear step count; clear `last_face_id` to 0. Next state is ISSUE.
- **ISSUE**
  - `step_valid=1` for exactly one cycle.
  - `step_*` driven from the cur registers; held stable in all states.
  - Load the watchdog with 0. Next state is WAIT.
- **WAIT**
  - Watchdog increments each cycle.
  - When `core_valid` arrives, evaluate in this priority order:
    - **HIT**: `core_occupied`. Result is the cur position and `last_face_id`. Go to DONE.
    - **MISS**: `core_oob` or wrap. wrap = OR over axes a of `core_face_mask[a] & (s_a ? cur_a==31 : cur_a==0)`. Face-mask bit mapping is bit0=x, bit1=y, bit2=z. Result is the cur position. Go to DONE.
    - **TIMEOUT**: count+1 == MAX_STEPS. Result is the core_i* position with `core_face_id`. Go to DONE.
    - **Otherwise**: count+1; cur position and timers ← `core_*`; `last_face_id` ← `core_face_id`. Go to ISSUE.
  - Watchdog reaching CORE_LAT+2 without `core_valid`: LOST. Result is the cur position. Go to DONE.
- **DONE**
  - `res_valid=1`; all `res_*` held stable.
  - `res_ready` returns to IDLE.
- `res_steps` = count after the terminating step's increment for TIMEOUT. For all other statuses it is the count at termination.
- `core_valid` outside WAIT is ignored. This covers stale results after reset.
- `load_mode` rising mid-ray does not abort the ray. System control must not load while `busy`.

## Timing
- Reset values:
  - state IDLE
  - `step_valid`, `res_valid`, `busy` 0
  - all `step_*` and `res_*` data 0
  - `res_status` 0
  - `ray_ready` 0 while `rst_n` low
- Step period is CORE_LAT+1 cycles (6).
- Acceptance at edge 0 gives ISSUE in cycle 1. `res_valid` rises in cycle 6·(N+1)+1, where N = `res_steps` (HIT/MISS).
- `res_valid` is held indefinitely under `res_ready=0`. `ray_ready` stays 0 until drained.
- `ray_valid` in the same cycle as the `res` handshake is not accepted. Acceptance occurs the cycle after.
- Reset mid-ray: immediate return to reset values; the in-flight core result is discarded.

## Structure
- Shared package `raytrace_pkg`:
  - `trav_status_e` (HIT/MISS/TIMEOUT/LOST)
  - `trav_state_e`
  - face-mask bit index constants `FACE_X/Y/Z`
  - `COORD_MAX=31`
- Sub-module `ray_exit_detect`: combinational wrap/oob detection from cur position, signs, `core_face_mask`, `core_oob`.

## Test plan
- **Hit**: scene bit (3,0,0) set; ray (0,0,0), sx=1, next=(10,100,100), inc_x=10. Expect HIT at (3,0,0), steps 3, face_id = core face from step 2→3, `res_valid` at cycle 25.
- **Wrap miss**: empty scene; ray (30,5,5), sx=1, next_x=1. Expect MISS at (31,5,5), steps 1, `res_valid` at cycle 13.
- **Timeout**: MAX_STEPS=4; empty scene; ray (0,0,0) along +x. Expect TIMEOUT at (4,0,0), steps 4.
- **Lost**: core stub never asserts `core_valid`. Expect LOST at start voxel, steps 0, `res_valid` 1+1+(CORE_LAT+2) cycles after acceptance.
- **Backpressure and load gating**: hold `res_ready=0` for 10 cycles; `res_*` stable, `ray_ready=0`. Then with `load_mode=1` in IDLE, `ray_ready` stays 0.
- **Reset mid-WAIT**: assert `rst_n=0` mid-WAIT. All outputs return to reset values; the stale `core_valid` arriving afterward produces no result.

Source files
------------

// File: rtl/raytrace_pkg.sv
// rtl/raytrace_pkg.sv - shared types and constants for the ray traversal blocks
// Contents: traversal status and controller state encodings, face-mask bit
// indices (bit0=x, bit1=y, bit2=z) and the largest voxel coordinate.
package raytrace_pkg;

    typedef enum logic [1:0] {
        ST_HIT     = 2'd0,
        ST_MISS    = 2'd1,
        ST_TIMEOUT = 2'd2,
        ST_LOST    = 2'd3
    } trav_status_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } trav_state_e;

    localparam int FACE_X = 0;
    localparam int FACE_Y = 1;
    localparam int FACE_Z = 2;

    localparam logic [4:0] COORD_MAX = 5'd31;

endpackage

// File: rtl/ray_exit_detect.sv
// rtl/ray_exit_detect.sv - combinational grid-exit detection for one step result
// Ports:
//   cur_ix/iy/iz  voxel that was issued to the core
//   dir_sx/sy/sz  step direction per axis, 1 = +
//   face_mask     axis the core stepped across (bit0=x, bit1=y, bit2=z)
//   oob           core reports the new position left the grid
//   wrap          the crossing axis was already on the boundary in its direction
//   grid_exit     wrap or oob
module ray_exit_detect
    import raytrace_pkg::*;
(
    input  logic [4:0] cur_ix,
    input  logic [4:0] cur_iy,
    input  logic [4:0] cur_iz,
    input  logic       dir_sx,
    input  logic       dir_sy,
    input  logic       dir_sz,
    input  logic [2:0] face_mask,
    input  logic       oob,
    output logic       wrap,
    output logic       grid_exit
);

    logic edge_x;
    logic edge_y;
    logic edge_z;

    // A 5-bit coordinate stepping past its boundary silently wraps in the
    // core, so the crossing must be caught from the pre-step position.
    assign edge_x = dir_sx ? (cur_ix == COORD_MAX) : (cur_ix == 5'd0);
    assign edge_y = dir_sy ? (cur_iy == COORD_MAX) : (cur_iy == 5'd0);
    assign edge_z = dir_sz ? (cur_iz == COORD_MAX) : (cur_iz == 5'd0);

    assign wrap = (face_mask[FACE_X] & edge_x)
                | (face_mask[FACE_Y] & edge_y)
                | (face_mask[FACE_Z] & edge_z);

    assign grid_exit = wrap | oob;

endmodule

// File: rtl/ray_traversal_ctrl.sv
// rtl/ray_traversal_ctrl.sv - per-ray step sequencer in front of the voxel raytracer core
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   load_mode                   scene load in progress, blocks ray acceptance
//   ray_valid/ray_ready, ray_*  initialised ray input
//   step_*, step_valid          single-step request to the core
//   core_*, core_valid          step result from the core
//   res_valid/res_ready, res_*  registered traversal result
//   busy                        controller not idle
module ray_traversal_ctrl
    import raytrace_pkg::*;
#(
    parameter int W         = 32,
    parameter int CORE_LAT  = 5,
    parameter int MAX_STEPS = 96,
    parameter int STEP_W    = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_mode,
    input  logic              ray_valid,
    output logic              ray_ready,
    input  logic [4:0]        ray_ix,
    input  logic [4:0]        ray_iy,
    input  logic [4:0]        ray_iz,
    input  logic              ray_sx,
    input  logic              ray_sy,
    input  logic              ray_sz,
    input  logic [W-1:0]      ray_next_x,
    input  logic [W-1:0]      ray_next_y,
    input  logic [W-1:0]      ray_next_z,
    input  logic [W-1:0]      ray_inc_x,
    input  logic [W-1:0]      ray_inc_y,
    input  logic [W-1:0]      ray_inc_z,
    output logic [4:0]        step_ix,
    output logic [4:0]        step_iy,
    output logic [4:0]        step_iz,
    output logic              step_sx,
    output logic              step_sy,
    output logic              step_sz,
    output logic [W-1:0]      step_next_x,
    output logic [W-1:0]      step_next_y,
    output logic [W-1:0]      step_next_z,
    output logic [W-1:0]      step_inc_x,
    output logic [W-1:0]      step_inc_y,
    output logic [W-1:0]      step_inc_z,
    output logic              step_valid,
    input  logic [4:0]        core_ix,
    input  logic [4:0]        core_iy,
    input  logic [4:0]        core_iz,
    input  logic [W-1:0]      core_next_x,
    input  logic [W-1:0]      core_next_y,
    input  logic [W-1:0]      core_next_z,
    input  logic [2:0]        core_face_mask,
    input  logic [2:0]        core_face_id,
    input  logic              core_oob,
    input  logic              core_occupied,
    input  logic              core_valid,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [1:0]        res_status,
    output logic [4:0]        res_ix,
    output logic [4:0]        res_iy,
    output logic [4:0]        res_iz,
    output logic [2:0]        res_face_id,
    output logic [STEP_W-1:0] res_steps,
    output logic              busy
);

    localparam int WD_W = $clog2(CORE_LAT + 3);

    trav_state_e       state;
    trav_state_e       state_nxt;

    logic [4:0]        cur_ix;
    logic [4:0]        cur_iy;
    logic [4:0]        cur_iz;
    logic              dir_sx;
    logic              dir_sy;
    logic              dir_sz;
    logic [W-1:0]      cur_next_x;
    logic [W-1:0]      cur_next_y;
    logic [W-1:0]      cur_next_z;
    logic [W-1:0]      cur_inc_x;
    logic [W-1:0]      cur_inc_y;
    logic [W-1:0]      cur_inc_z;
    logic [STEP_W-1:0] step_cnt;
    logic [2:0]        last_face_id;
    logic [WD_W-1:0]   wd;
    trav_status_e      res_status_q;

    logic              accept;
    logic [STEP_W-1:0] cnt_inc;
    logic [WD_W-1:0]   wd_inc;
    logic              hit_now;
    logic              wrap_now;
    logic              grid_exit;
    logic              limit_now;
    logic              lost_now;

    ray_exit_detect u_exit_detect (
        .cur_ix    (cur_ix),
        .cur_iy    (cur_iy),
        .cur_iz    (cur_iz),
        .dir_sx    (dir_sx),
        .dir_sy    (dir_sy),
        .dir_sz    (dir_sz),
        .face_mask (core_face_mask),
        .oob       (core_oob),
        .wrap      (wrap_now),
        .grid_exit (grid_exit)
    );

    // rst_n is left out here so the registers never depend on it outside reset.
    assign accept    = ray_valid & (state == S_IDLE) & ~load_mode;
    assign cnt_inc   = step_cnt + STEP_W'(1);
    assign wd_inc    = wd + WD_W'(1);
    assign hit_now   = core_occupied;
    assign limit_now = (cnt_inc == STEP_W'(MAX_STEPS));
    // Fires on the last WAIT cycle in which a result could still have arrived.
    assign lost_now  = (wd_inc == WD_W'(CORE_LAT + 2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (core_valid) begin
                    if (hit_now || grid_exit || limit_now) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_ISSUE;
                    end
                end else if (lost_now) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ray_ready  = (state == S_IDLE) & ~load_mode & rst_n;
        step_valid = (state == S_ISSUE);
        res_valid  = (state == S_DONE);
        busy       = (state != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_ix       <= '0;
            cur_iy       <= '0;
            cur_iz       <= '0;
            dir_sx       <= 1'b0;
            dir_sy       <= 1'b0;
            dir_sz       <= 1'b0;
            cur_next_x   <= '0;
            cur_next_y   <= '0;
            cur_next_z   <= '0;
            cur_inc_x    <= '0;
            cur_inc_y    <= '0;
            cur_inc_z    <= '0;
            step_cnt     <= '0;
            last_face_id <= '0;
            wd           <= '0;
            res_status_q <= ST_HIT;
            res_ix       <= '0;
            res_iy       <= '0;
            res_iz       <= '0;
            res_face_id  <= '0;
            res_steps    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cur_ix       <= ray_ix;
                        cur_iy       <= ray_iy;
                        cur_iz       <= ray_iz;
                        dir_sx       <= ray_sx;
                        dir_sy       <= ray_sy;
                        dir_sz       <= ray_sz;
                        cur_next_x   <= ray_next_x;
                        cur_next_y   <= ray_next_y;
                        cur_next_z   <= ray_next_z;
                        cur_inc_x    <= ray_inc_x;
                        cur_inc_y    <= ray_inc_y;
                        cur_inc_z    <= ray_inc_z;
                        step_cnt     <= '0;
                        last_face_id <= '0;
                    end
                end
                S_ISSUE: begin
                    wd <= '0;
                end
                S_WAIT: begin
                    wd <= wd_inc;
                    if (core_valid) begin
                        if (hit_now) begin
                            res_status_q <= ST_HIT;
                            res_ix       <= cur_ix;
                            res_iy       <= cur_iy;
                            res_iz       <= cur_iz;
                            res_face_id  <= last_face_id;
                            res_steps    <= step_cnt;
                        end else if (grid_exit) begin
                            res_status_q <= ST_MISS;
                            res_ix       <= cur_ix;
                            res_iy       <= cur_iy;
                            res_iz       <= cur_iz;
                            res_face_id  <= last_face_id;
                            res_steps    <= step_cnt;
                        end else if (limit_now) begin
                            // The limiting step did complete, so report where it landed.
                            res_status_q <= ST_TIMEOUT;
                            res_ix       <= core_ix;
                            res_iy       <= core_iy;
                            res_iz       <= core_iz;
                            res_face_id  <= core_face_id;
                            res_steps    <= cnt_inc;
                        end else begin
                            step_cnt     <= cnt_inc;
                            cur_ix       <= core_ix;
                            cur_iy       <= core_iy;
                            cur_iz       <= core_iz;
                            cur_next_x   <= core_next_x;
                            cur_next_y   <= core_next_y;
                            cur_next_z   <= core_next_z;
                            last_face_id <= core_face_id;
                        end
                    end else if (lost_now) begin
                        res_status_q <= ST_LOST;
                        res_ix       <= cur_ix;
                        res_iy       <= cur_iy;
                        res_iz       <= cur_iz;
                        res_face_id  <= last_face_id;
                        res_steps    <= step_cnt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign res_status  = res_status_q;
    assign step_ix     = cur_ix;
    assign step_iy     = cur_iy;
    assign step_iz     = cur_iz;
    assign step_sx     = dir_sx;
    assign step_sy     = dir_sy;
    assign step_sz     = dir_sz;
    assign step_next_x = cur_next_x;
    assign step_next_y = cur_next_y;
    assign step_next_z = cur_next_z;
    assign step_inc_x  = cur_inc_x;
    assign step_inc_y  = cur_inc_y;
    assign step_inc_z  = cur_inc_z;

endmodule

// File: tb/tb_ray_traversal_ctrl.sv
// tb/tb_ray_traversal_ctrl.sv - directed self-checking bench for ray_traversal_ctrl
module tb_ray_traversal_ctrl;

    localparam int W = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_mode;
    logic        ray_valid;
    logic        ray_ready;
    logic [4:0]  ray_ix, ray_iy, ray_iz;
    logic        ray_sx, ray_sy, ray_sz;
    logic [W-1:0] ray_next_x, ray_next_y, ray_next_z;
    logic [W-1:0] ray_inc_x, ray_inc_y, ray_inc_z;
    logic [4:0]  step_ix, step_iy, step_iz;
    logic        step_sx, step_sy, step_sz;
    logic [W-1:0] step_next_x, step_next_y, step_next_z;
    logic [W-1:0] step_inc_x, step_inc_y, step_inc_z;
    logic        step_valid;
    logic [4:0]  core_ix, core_iy, core_iz;
    logic [W-1:0] core_next_x, core_next_y, core_next_z;
    logic [2:0]  core_face_mask, core_face_id;
    logic        core_oob;
    logic        core_occupied;
    logic        core_valid;
    logic        res_valid;
    logic        res_ready;
    logic [1:0]  res_status;
    logic [4:0]  res_ix, res_iy, res_iz;
    logic [2:0]  res_face_id;
    logic [6:0]  res_steps;
    logic        busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ray_traversal_ctrl #(.W(W), .CORE_LAT(5), .MAX_STEPS(4), .STEP_W(7)) dut (
        .clk(clk), .rst_n(rst_n), .load_mode(load_mode),
        .ray_valid(ray_valid), .ray_ready(ray_ready),
        .ray_ix(ray_ix), .ray_iy(ray_iy), .ray_iz(ray_iz),
        .ray_sx(ray_sx), .ray_sy(ray_sy), .ray_sz(ray_sz),
        .ray_next_x(ray_next_x), .ray_next_y(ray_next_y), .ray_next_z(ray_next_z),
        .ray_inc_x(ray_inc_x), .ray_inc_y(ray_inc_y), .ray_inc_z(ray_inc_z),
        .step_ix(step_ix), .step_iy(step_iy), .step_iz(step_iz),
        .step_sx(step_sx), .step_sy(step_sy), .step_sz(step_sz),
        .step_next_x(step_next_x), .step_next_y(step_next_y), .step_next_z(step_next_z),
        .step_inc_x(step_inc_x), .step_inc_y(step_inc_y), .step_inc_z(step_inc_z),
        .step_valid(step_valid),
        .core_ix(core_ix), .core_iy(core_iy), .core_iz(core_iz),
        .core_next_x(core_next_x), .core_next_y(core_next_y), .core_next_z(core_next_z),
        .core_face_mask(core_face_mask), .core_face_id(core_face_id),
        .core_oob(core_oob), .core_occupied(core_occupied), .core_valid(core_valid),
        .res_valid(res_valid), .res_ready(res_ready), .res_status(res_status),
        .res_ix(res_ix), .res_iy(res_iy), .res_iz(res_iz),
        .res_face_id(res_face_id), .res_steps(res_steps), .busy(busy)
    );

    // Core stand-in: steps across the axis with the smallest next timer,
    // reports occupancy of the voxel it was given, answers 5 cycles later.
    // Face ids: x+ 1, x- 2, y+ 3, y- 4, z+ 5, z- 6. Not reset with the DUT.
    typedef struct packed {
        logic [4:0]   ix, iy, iz;
        logic [W-1:0] nx, ny, nz;
        logic [2:0]   mask, face;
        logic         occ;
    } core_res_t;

    logic       stub_en;
    logic       hit_en;
    logic [4:0] hit_x, hit_y, hit_z;
    core_res_t  s_res;
    core_res_t  pipe [0:4];
    logic [4:0] pv = '0;

    always_comb begin
        s_res      = '0;
        s_res.ix   = step_ix;
        s_res.iy   = step_iy;
        s_res.iz   = step_iz;
        s_res.nx   = step_next_x;
        s_res.ny   = step_next_y;
        s_res.nz   = step_next_z;
        if (step_next_x <= step_next_y && step_next_x <= step_next_z) begin
            s_res.ix   = step_sx ? step_ix + 5'd1 : step_ix - 5'd1;
            s_res.nx   = step_next_x + step_inc_x;
            s_res.mask = 3'b001;
            s_res.face = step_sx ? 3'd1 : 3'd2;
        end else if (step_next_y <= step_next_z) begin
            s_res.iy   = step_sy ? step_iy + 5'd1 : step_iy - 5'd1;
            s_res.ny   = step_next_y + step_inc_y;
            s_res.mask = 3'b010;
            s_res.face = step_sy ? 3'd3 : 3'd4;
        end else begin
            s_res.iz   = step_sz ? step_iz + 5'd1 : step_iz - 5'd1;
            s_res.nz   = step_next_z + step_inc_z;
            s_res.mask = 3'b100;
            s_res.face = step_sz ? 3'd5 : 3'd6;
        end
        s_res.occ = hit_en && step_ix == hit_x && step_iy == hit_y && step_iz == hit_z;
    end

    always @(posedge clk) begin
        pv      <= {pv[3:0], step_valid & stub_en};
        pipe[0] <= s_res;
        for (int k = 1; k < 5; k++) pipe[k] <= pipe[k-1];
    end

    assign core_valid     = pv[4];
    assign core_ix        = pipe[4].ix;
    assign core_iy        = pipe[4].iy;
    assign core_iz        = pipe[4].iz;
    assign core_next_x    = pipe[4].nx;
    assign core_next_y    = pipe[4].ny;
    assign core_next_z    = pipe[4].nz;
    assign core_face_mask = pipe[4].mask;
    assign core_face_id   = pipe[4].face;
    assign core_occupied  = pipe[4].occ;
    assign core_oob       = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [4:0]   ix, iy, iz;
        logic         sx, sy, sz;
        logic [W-1:0] nx, ny, nz, incx, incy, incz;
        logic         core_en, hit_en;
        logic [4:0]   hx, hy, hz;
        logic [1:0]   e_status;
        logic [4:0]   e_ix, e_iy, e_iz;
        logic [2:0]   e_face;
        logic [6:0]   e_steps;
        int           e_cycle;
        int           e_issues;
    } vec_t;

    vec_t vecs [6];

    task automatic run_vec(input int idx, input vec_t v);
        int    cyc;
        int    issues;
        string p;
        p = $sformatf("v%0d", idx);
        @(negedge clk);
        stub_en = v.core_en; hit_en = v.hit_en;
        hit_x = v.hx; hit_y = v.hy; hit_z = v.hz;
        ray_ix = v.ix; ray_iy = v.iy; ray_iz = v.iz;
        ray_sx = v.sx; ray_sy = v.sy; ray_sz = v.sz;
        ray_next_x = v.nx; ray_next_y = v.ny; ray_next_z = v.nz;
        ray_inc_x = v.incx; ray_inc_y = v.incy; ray_inc_z = v.incz;
        ray_valid = 1'b1;
        for (int k = 0; k < 20 && !ray_ready; k++) @(negedge clk);
        check({p, "_ray_ready"}, ray_ready, 1);
        @(posedge clk);
        cyc = 0;
        issues = 0;
        do begin
            @(negedge clk);
            cyc++;
            ray_valid = 1'b0;
            if (step_valid) issues++;
        end while (!res_valid && cyc < 300);
        check({p, "_res_valid"}, res_valid, 1);
        check({p, "_cycle"}, cyc, v.e_cycle);
        check({p, "_status"}, res_status, v.e_status);
        check({p, "_pos"}, {res_ix, res_iy, res_iz}, {v.e_ix, v.e_iy, v.e_iz});
        check({p, "_face"}, res_face_id, v.e_face);
        check({p, "_steps"}, res_steps, v.e_steps);
        check({p, "_issues"}, issues, v.e_issues);
        @(negedge clk);
        check({p, "_drained"}, {busy, res_valid}, 2'b00);
    endtask

    initial begin
        // ix iy iz, sx sy sz, next xyz, inc xyz, core_en, hit_en, hit xyz, status, pos, face, steps, cycle, issues
        vecs[0] = '{5'd0, 5'd0, 5'd0, 1, 1, 1, 10, 100, 100, 10, 100, 100, 1, 1, 5'd3, 5'd0, 5'd0,
                    2'd0, 5'd3, 5'd0, 5'd0, 3'd1, 7'd3, 25, 4};
        vecs[1] = '{5'd30, 5'd5, 5'd5, 1, 1, 1, 1, 100, 100, 10, 10, 10, 1, 0, 5'd0, 5'd0, 5'd0,
                    2'd1, 5'd31, 5'd5, 5'd5, 3'd1, 7'd1, 13, 2};
        vecs[2] = '{5'd1, 5'd2, 5'd3, 0, 1, 1, 1, 100, 100, 10, 10, 10, 1, 0, 5'd0, 5'd0, 5'd0,
                    2'd1, 5'd0, 5'd2, 5'd3, 3'd2, 7'd1, 13, 2};
        vecs[3] = '{5'd4, 5'd4, 5'd4, 1, 1, 1, 100, 5, 100, 1, 3, 1, 1, 1, 5'd4, 5'd6, 5'd4,
                    2'd0, 5'd4, 5'd6, 5'd4, 3'd3, 7'd2, 19, 3};
        vecs[4] = '{5'd0, 5'd0, 5'd0, 1, 1, 1, 1, 100, 100, 1, 1, 1, 1, 0, 5'd0, 5'd0, 5'd0,
                    2'd2, 5'd4, 5'd0, 5'd0, 3'd1, 7'd4, 25, 4};
        vecs[5] = '{5'd7, 5'd8, 5'd9, 1, 1, 1, 1, 100, 100, 1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0,
                    2'd3, 5'd7, 5'd8, 5'd9, 3'd0, 7'd0, 9, 1};

        rst_n = 1'b0; load_mode = 1'b0; ray_valid = 1'b0; res_ready = 1'b1;
        ray_ix = '0; ray_iy = '0; ray_iz = '0; ray_sx = 1'b0; ray_sy = 1'b0; ray_sz = 1'b0;
        ray_next_x = '0; ray_next_y = '0; ray_next_z = '0;
        ray_inc_x = '0; ray_inc_y = '0; ray_inc_z = '0;
        stub_en = 1'b1; hit_en = 1'b0; hit_x = '0; hit_y = '0; hit_z = '0;

        repeat (3) @(negedge clk);
        check("reset_ray_ready", ray_ready, 0);
        check("reset_ctrl", {busy, step_valid, res_valid}, 3'b000);
        check("reset_res", {res_status, res_ix, res_iy, res_iz, res_face_id, res_steps}, 0);
        check("reset_step", {step_ix, step_iy, step_iz, step_next_x}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ray_ready", ray_ready, 1);

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Backpressure: LOST result held under res_ready=0 with a waiting ray.
        @(negedge clk);
        stub_en = 1'b0; res_ready = 1'b0;
        ray_ix = 5'd7; ray_iy = 5'd8; ray_iz = 5'd9;
        ray_valid = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 30 && !res_valid; k++) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check($sformatf("bp_hold%0d", k),
                  {res_valid, ray_ready, res_status, res_ix, res_iy, res_iz, res_steps},
                  {1'b1, 1'b0, 2'd3, 5'd7, 5'd8, 5'd9, 7'd0});
        end
        res_ready = 1'b1;
        check("bp_handshake_ray_ready", ray_ready, 0);
        @(negedge clk);
        check("bp_after_drain", {busy, ray_ready}, 2'b01);
        ray_valid = 1'b0;

        // Load gating in IDLE.
        load_mode = 1'b1;
        ray_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("load_gate%0d", k), {ray_ready, busy}, 2'b00);
        end
        ray_valid = 1'b0;
        load_mode = 1'b0;
        @(negedge clk);
        check("load_release", ray_ready, 1);

        // Reset during WAIT; the in-flight core result must be discarded.
        stub_en = 1'b1; hit_en = 1'b0;
        ray_ix = 5'd2; ray_iy = 5'd2; ray_iz = 5'd2;
        ray_sx = 1'b1; ray_sy = 1'b1; ray_sz = 1'b1;
        ray_next_x = 1; ray_next_y = 100; ray_next_z = 100;
        ray_inc_x = 1; ray_inc_y = 1; ray_inc_z = 1;
        ray_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ray_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_pre_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_ctrl", {busy, step_valid, res_valid, ray_ready}, 4'b0000);
        check("rst_mid_step", {step_ix, step_iy, step_iz, step_sx, step_next_x, step_inc_x}, 0);
        check("rst_mid_res", {res_status, res_ix, res_face_id, res_steps}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check($sformatf("rst_stale%0d", k), {res_valid, busy}, 2'b00);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
